// File: rtl/sdf_stage_ctrl.sv
// -----------------------------------------------------------------------------
// sdf_stage_ctrl
//
// Sequencing controller for one radix-2 single-delay-feedback FFT stage.
// After PRE pipeline-latency samples the stage alternates between a FILL
// phase (DELAY samples pushed into the delay line) and a BFLY phase (DELAY
// samples combined with the delay-line output). During BFLY the twiddle ROM
// address steps by TW_STRIDE per sample. The sequence repeats forever.
//
// Ports
//   clk        : single clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : one sample accepted per cycle while high
//   sync_clr   : synchronous clear back to the post-reset condition
//   state      : stage mode, 0 = WAIT, 1 = FILL, 2 = BFLY (3 never driven)
//   tw_addr    : twiddle ROM address, nonzero only in BFLY
//   out_valid  : stage output valid this cycle
//   frame_done : one-cycle pulse after the last BFLY sample of a phase
// -----------------------------------------------------------------------------
module sdf_stage_ctrl #(
    parameter int  DELAY     = 256,
    parameter int  PRE       = 2,
    parameter int  TW_STRIDE = 1,
    localparam int AW        = $clog2(DELAY)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          sync_clr,
    output logic [1:0]    state,
    output logic [AW-1:0] tw_addr,
    output logic          out_valid,
    output logic          frame_done
);

    localparam int PW = $clog2(PRE + 1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_FILL = 2'd1,
        ST_BFLY = 2'd2
    } state_e;

    // Twiddle address: product taken at full width, then reduced modulo the
    // power-of-two DELAY by truncation.
    function automatic logic [AW-1:0] tw_calc(input logic [AW-1:0] idx);
        return AW'(32'(idx) * 32'(TW_STRIDE));
    endfunction

    logic [PW-1:0] pre_cnt_q,    pre_cnt_d;
    logic          primed_q,     primed_d;
    logic          phase_q,      phase_d;
    logic [AW-1:0] idx_q,        idx_d;
    logic          seen_bfly_q,  seen_bfly_d;
    logic          frame_done_q, frame_done_d;

    state_e        state_s;

    // Stage mode decoded purely from the registered primed/phase bits.
    always_comb begin
        state_s = ST_WAIT;
        if (!primed_q) begin
            state_s = ST_WAIT;
        end else if (!phase_q) begin
            state_s = ST_FILL;
        end else begin
            state_s = ST_BFLY;
        end
    end

    // Next-state logic: clear wins over a sample; stalls hold everything
    // except the frame_done pulse, which always falls back to 0.
    always_comb begin
        pre_cnt_d    = pre_cnt_q;
        primed_d     = primed_q;
        phase_d      = phase_q;
        idx_d        = idx_q;
        seen_bfly_d  = seen_bfly_q;
        frame_done_d = 1'b0;

        if (sync_clr) begin
            pre_cnt_d    = '0;
            primed_d     = 1'b0;
            phase_d      = 1'b0;
            idx_d        = '0;
            seen_bfly_d  = 1'b0;
            frame_done_d = 1'b0;
        end else if (in_valid) begin
            if (!primed_q) begin
                // Last latency sample: enter FILL at the start of the delay line.
                if (pre_cnt_q == PW'(PRE - 1)) begin
                    pre_cnt_d = PW'(PRE);
                    primed_d  = 1'b1;
                    phase_d   = 1'b0;
                    idx_d     = '0;
                end else begin
                    pre_cnt_d = pre_cnt_q + PW'(1);
                end
            end else begin
                if (idx_q == AW'(DELAY - 1)) begin
                    idx_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    idx_d   = idx_q + AW'(1);
                end
            end

            if (state_s == ST_BFLY) begin
                seen_bfly_d  = 1'b1;
                frame_done_d = (idx_q == AW'(DELAY - 1));
            end else begin
                seen_bfly_d  = seen_bfly_q;
                frame_done_d = 1'b0;
            end
        end else begin
            frame_done_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q    <= '0;
            primed_q     <= 1'b0;
            phase_q      <= 1'b0;
            idx_q        <= '0;
            seen_bfly_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            primed_q     <= primed_d;
            phase_q      <= phase_d;
            idx_q        <= idx_d;
            seen_bfly_q  <= seen_bfly_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Output mapping; out_valid follows in_valid so a stall drops it at once.
    always_comb begin
        state      = state_s;
        tw_addr    = '0;
        if (state_s == ST_BFLY) begin
            tw_addr = tw_calc(idx_q);
        end else begin
            tw_addr = '0;
        end
        out_valid  = in_valid & (seen_bfly_q | (state_s == ST_BFLY));
        frame_done = frame_done_q;
    end

endmodule

// File: tb/tb_sdf_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sdf_stage_ctrl
//
// Two instances share one stimulus stream: dut_a (DELAY=4, PRE=2, STRIDE=1)
// and dut_b (DELAY=8, PRE=2, STRIDE=2). The reference model only counts
// accepted samples since the last reset/clear and derives every output from
// that count arithmetically. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_sdf_stage_ctrl;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       in_valid = 1'b0;
    logic       sync_clr = 1'b0;

    logic [1:0] st_a, st_b;
    logic [1:0] tw_a;
    logic [2:0] tw_b;
    logic       ov_a, ov_b, fd_a, fd_b;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    int rec_st   [1:40];
    int rec_tw_a [1:40];
    int rec_ov   [1:40];
    int rec_fd   [1:40];
    int rec_tw_b [1:40];

    always #5 clk = ~clk;

    sdf_stage_ctrl #(.DELAY(4), .PRE(2), .TW_STRIDE(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sync_clr(sync_clr),
        .state(st_a), .tw_addr(tw_a), .out_valid(ov_a), .frame_done(fd_a)
    );

    sdf_stage_ctrl #(.DELAY(8), .PRE(2), .TW_STRIDE(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sync_clr(sync_clr),
        .state(st_b), .tw_addr(tw_b), .out_valid(ov_b), .frame_done(fd_b)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   n_acc     = 0;
    logic fd_a_exp  = 1'b0;
    logic fd_b_exp  = 1'b0;

    function automatic logic is_last_bfly(input int n, input int d, input int p);
        return (n >= p) && (((n - p) % (2 * d)) == (2 * d - 1));
    endfunction

    function automatic void exp_out(input int n, input int d, input int p, input int s,
                                    input logic v, output int st, output int tw, output int ov);
        int m;
        m  = n - p;
        if (n < p)                  st = 0;
        else if (((m / d) % 2) == 0) st = 1;
        else                        st = 2;
        tw = (st == 2) ? (((m % d) * s) % d) : 0;
        ov = (v && ((n > p + d) || st == 2)) ? 1 : 0;
    endfunction

    // Count of accepted samples; frame_done expectation from the sample index.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || sync_clr) begin
            n_acc    <= 0;
            fd_a_exp <= 1'b0;
            fd_b_exp <= 1'b0;
        end else if (in_valid) begin
            n_acc    <= n_acc + 1;
            fd_a_exp <= is_last_bfly(n_acc, 4, 2);
            fd_b_exp <= is_last_bfly(n_acc, 8, 2);
        end else begin
            fd_a_exp <= 1'b0;
            fd_b_exp <= 1'b0;
        end
    end

    int e_st, e_tw, e_ov;

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_out(n_acc, 4, 2, 1, in_valid, e_st, e_tw, e_ov);
            chk("a_state", int'(st_a), e_st);
            chk("a_tw",    int'(tw_a), e_tw);
            chk("a_ov",    int'(ov_a), e_ov);
            chk("a_fd",    int'(fd_a), int'(fd_a_exp));
            exp_out(n_acc, 8, 2, 2, in_valid, e_st, e_tw, e_ov);
            chk("b_state", int'(st_b), e_st);
            chk("b_tw",    int'(tw_b), e_tw);
            chk("b_ov",    int'(ov_b), e_ov);
            chk("b_fd",    int'(fd_b), int'(fd_b_exp));
        end
    end

    // Structural invariants: illegal mode and back-to-back frame_done.
    logic fd_a_prev = 1'b0;
    logic fd_b_prev = 1'b0;
    always @(negedge clk) begin
        assert (st_a != 2'd3 && st_b != 2'd3)
            else $error("FAIL assert_state3 a=%0d b=%0d", st_a, st_b);
        assert (!(fd_a && fd_a_prev) && !(fd_b && fd_b_prev))
            else $error("FAIL assert_fd_consecutive");
        fd_a_prev <= fd_a;
        fd_b_prev <= fd_b;
    end

    // ---------------- stimulus ----------------
    task automatic run_cycle(input logic v, input logic c, input int k);
        in_valid = v;
        sync_clr = c;
        @(negedge clk);
        if (k >= 1 && k <= 40) begin
            rec_st[k]   = int'(st_a);
            rec_tw_a[k] = int'(tw_a);
            rec_ov[k]   = int'(ov_a);
            rec_fd[k]   = int'(fd_a);
            rec_tw_b[k] = int'(tw_b);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        sync_clr = 1'b0;
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("rst_state", int'(st_a), 0);
        chk("rst_tw",    int'(tw_a), 0);
        chk("rst_ov",    int'(ov_a), 0);
        chk("rst_fd",    int'(fd_a), 0);
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    // Continuous input from a clean start; literal expectations of the
    // reference sequence (DELAY=4 and the DELAY=8 / stride-2 instance).
    task automatic check_base(input string tag);
        int exp_st [12];
        int exp_twb[8];
        exp_st  = '{0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 1, 1};
        exp_twb = '{0, 2, 4, 6, 0, 2, 4, 6};
        for (int k = 1; k <= 30; k++) run_cycle(1'b1, 1'b0, k);
        for (int k = 1; k <= 12; k++) chk({tag, "_lit_state"}, rec_st[k], exp_st[k-1]);
        for (int k = 7; k <= 10; k++) chk({tag, "_lit_tw"}, rec_tw_a[k], k - 7);
        chk({tag, "_lit_ov1"},  rec_ov[1],  0);
        chk({tag, "_lit_ov6"},  rec_ov[6],  0);
        chk({tag, "_lit_ov7"},  rec_ov[7],  1);
        chk({tag, "_lit_ov12"}, rec_ov[12], 1);
        chk({tag, "_lit_ov30"}, rec_ov[30], 1);
        for (int k = 1; k <= 30; k++)
            chk({tag, "_lit_fd"}, rec_fd[k], (k == 11 || k == 19 || k == 27) ? 1 : 0);
        for (int k = 11; k <= 18; k++) chk({tag, "_lit_twb"}, rec_tw_b[k], exp_twb[k-11]);
    endtask

    initial begin
        // Scenario 1: continuous input after reset.
        do_reset();
        chk_en = 1'b1;
        check_base("s1");

        // Scenario 2: three-cycle stall while BFLY idx=1 is presented.
        do_reset();
        for (int k = 1; k <= 7; k++)   run_cycle(1'b1, 1'b0, k);
        for (int k = 8; k <= 10; k++)  run_cycle(1'b0, 1'b0, k);
        for (int k = 11; k <= 20; k++) run_cycle(1'b1, 1'b0, k);
        for (int k = 8; k <= 10; k++) begin
            chk("s2_stall_state", rec_st[k],   2);
            chk("s2_stall_tw",    rec_tw_a[k], 1);
            chk("s2_stall_ov",    rec_ov[k],   0);
            chk("s2_stall_fd",    rec_fd[k],   0);
        end
        chk("s2_resume_tw11", rec_tw_a[11], 1);
        chk("s2_resume_tw12", rec_tw_a[12], 2);
        chk("s2_fd11",        rec_fd[11],   0);
        chk("s2_fd14",        rec_fd[14],   1);

        // Scenario 3: sync_clr with a valid sample during BFLY idx=2.
        do_reset();
        for (int k = 1; k <= 8; k++) run_cycle(1'b1, 1'b0, k);
        run_cycle(1'b1, 1'b1, 9);
        chk("s3_pre_clr_state", rec_st[9],   2);
        chk("s3_pre_clr_tw",    rec_tw_a[9], 2);
        check_base("s3");

        // Scenario 4: asynchronous reset pulse between edges during FILL.
        do_reset();
        for (int k = 1; k <= 3; k++) run_cycle(1'b1, 1'b0, k);
        in_valid = 1'b1;
        chk("s4_before_state", int'(st_a), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("s4_async_state", int'(st_a), 0);
        chk("s4_async_tw",    int'(tw_a), 0);
        chk("s4_async_ov",    int'(ov_a), 0);
        chk("s4_async_fd",    int'(fd_a), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        check_base("s4");

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sdf_stage_ctrl.md
SDF_STAGE_CTRL -- requirements
Module: sdf_stage_ctrl

Interface
REQ-001 The block SHALL have parameter DELAY, default 256: delay-line length of the controlled radix-2 SDF stage; power of two, at least 2.
REQ-002 The block SHALL have parameter PRE, default 2: pipeline-latency samples accepted before the first FILL phase; at least 1.
REQ-003 The block SHALL have parameter TW_STRIDE, default 1: twiddle address step per BFLY sample.
REQ-004 The block SHALL define localparam AW = log2(DELAY).
REQ-005 Port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset; asynchronous, active-low.
REQ-007 Port in_valid, input, 1 bit: one sample accepted per cycle while high.
REQ-008 Port sync_clr, input, 1 bit: synchronous soft clear to the post-reset condition.
REQ-009 Port state, output, 2 bits: stage mode. 0 = WAIT, 1 = FILL, 2 = BFLY; value 3 is never driven.
REQ-010 Port tw_addr, output, AW bits: twiddle ROM address.
REQ-011 Port out_valid, output, 1 bit: the stage output is valid this cycle.
REQ-012 Port frame_done, output, 1 bit: one-cycle pulse at the end of each BFLY phase.

Function
REQ-013 The block SHALL hold these registers: pre_cnt (ceil(log2(PRE+1)) bits), primed, phase (0 = FILL, 1 = BFLY), idx (AW bits), seen_bfly, frame_done.
REQ-014 An accepted sample is a rising clock edge with in_valid=1 and sync_clr=0; on every other edge all registers SHALL hold, except for REQ-020 and REQ-021.
REQ-015 While primed=0, each accepted sample SHALL increment pre_cnt; the sample that makes pre_cnt equal PRE SHALL set primed=1 with phase=0 and idx=0.
REQ-016 While primed=1, each accepted sample SHALL increment idx modulo DELAY; when idx=DELAY-1, idx SHALL wrap to 0 and phase SHALL toggle.
REQ-017 Outputs state and tw_addr SHALL be combinational from registers only: state = 0 if primed=0, else 1 if phase=0, else 2.
REQ-018 tw_addr SHALL equal (idx*TW_STRIDE) mod DELAY, truncated to AW bits, when state=2, and 0 otherwise.
REQ-019 seen_bfly SHALL set on the first accepted sample with state=2 and SHALL then stay set until reset or sync_clr.
REQ-020 out_valid SHALL equal in_valid AND (seen_bfly OR state=2); it is therefore high from the first BFLY sample onward, in both phases.
REQ-021 frame_done SHALL be registered: it is 1 on the cycle after an accepted sample with state=2 and idx=DELAY-1, and 0 on all other cycles, including stall cycles.
REQ-022 A stall (in_valid=0) SHALL freeze state and tw_addr at their current values, and out_valid SHALL be 0.
REQ-023 sync_clr=1 SHALL win over a simultaneous in_valid=1: that sample is discarded and all registers return to their reset values on that edge.
REQ-024 Phase wrap and frame_done SHALL repeat indefinitely; the block has no terminal state.

Reset
REQ-025 While rst_n=0, all registers SHALL be 0 immediately, independent of clk: pre_cnt=0, primed=0, phase=0, idx=0, seen_bfly=0, frame_done=0.
REQ-026 During reset, outputs SHALL therefore be state=0, tw_addr=0, out_valid=0 and frame_done=0.
REQ-027 Deasserting rst_n mid-frame SHALL restart the sequence with the WAIT state, with no residual phase carried over.

Verification (DELAY=4, PRE=2, TW_STRIDE=1 unless stated)
REQ-028 Reset, then in_valid=1 continuously: state sequence SHALL be 0,0, then 1 x4, then 2 x4, then 1 x4, and so on. tw_addr SHALL be 0,1,2,3 during each BFLY phase. out_valid SHALL first be 1 on cycle 7 and stay 1. frame_done SHALL pulse on cycles 11, 19 and 27.
REQ-029 Continuous input with in_valid=0 for 3 cycles inserted at BFLY idx=1: state=2 and tw_addr=1 SHALL hold through the stall, out_valid=0 during it, and the sequence SHALL resume at idx=2 with frame_done delayed by 3 cycles.
REQ-030 sync_clr=1 asserted together with in_valid=1 during BFLY idx=2: on the next cycle state=0, tw_addr=0 and out_valid=0, and the sequence SHALL restart exactly as in REQ-028.
REQ-031 rst_n pulsed low asynchronously between clock edges in FILL: outputs SHALL go to 0 without waiting for a clock edge, and the post-release sequence SHALL match REQ-028.
REQ-032 With TW_STRIDE=2 and DELAY=8, continuous input: tw_addr during BFLY SHALL be 0,2,4,6,0,2,4,6.
REQ-033 A bench assertion SHALL check that state never equals 3 and that frame_done is never high on two consecutive cycles.
